// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Parametrised 2-read / 1-write register file with:
//     - optional hardwired-zero entry 0 (ZERO_REG)
//     - optional same-cycle write-to-read bypass (BYPASS)
//     - per-register busy scoreboard for long-latency producers
//     - post-reset clear sequencer (INIT walks every entry writing 0)
//
// Ports
//   clk           clock, all state updates on rising edge
//   reset         asynchronous active-high; clears sequencer and scoreboard
//   rs, rt        read addresses for port 1 / port 2
//   rd            write address
//   reg_write     write enable
//   write_data    write data
//   reserve       mark reserve_addr busy (producer issued)
//   reserve_addr  register to reserve
//   read_data1/2  combinational read data for rs / rt
//   busy1/2       rs / rt has an outstanding producer
//   init_done     clear sequence complete; file usable
//
// State | Meaning
// ------+-----------------------------------------------------------
// INIT  | clearing entry[ptr] each edge; ports ignored, outputs 0
// RUN   | normal operation: writes, reserves, reads, bypass
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy1,
    output logic              busy2,
    output logic              init_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q,   ptr_d;
    logic [DEPTH-1:0]    busy_q,  busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                run;
    logic                wr_ok;
    logic                res_ok;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Qualified write / reserve: only in RUN, and never to entry 0 when it
    // is hardwired.
    always_comb begin
        run    = (state_q == S_RUN);
        wr_ok  = run && reg_write && !(ZERO_REG && (rd == '0));
        res_ok = run && reserve   && !(ZERO_REG && (reserve_addr == '0));
    end

    // Sequencer next-state and storage write port steering.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = rd;
        mem_wdata = write_data;
        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    // Last entry cleared: stop here rather than wrapping.
                    state_d = S_RUN;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            S_RUN: begin
                mem_we = wr_ok;
            end
            default: begin
                state_d = S_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Scoreboard: write clears, reserve sets. Reserve is applied last so a
    // same-edge write and reserve to one register leaves it busy (the
    // reserving instruction is the newer producer).
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[rd] = 1'b0;
        end
        if (res_ok) begin
            busy_d[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Storage carries no reset; the INIT walk is what makes it defined.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read port 1
    always_comb begin
        read_data1 = '0;
        busy1      = 1'b0;
        if (run && !(ZERO_REG && (rs == '0))) begin
            if (BYPASS && wr_ok && (rd == rs)) begin
                read_data1 = write_data;
            end else begin
                read_data1 = mem_q[rs];
                busy1      = busy_q[rs];
            end
        end
    end

    // Read port 2
    always_comb begin
        read_data2 = '0;
        busy2      = 1'b0;
        if (run && !(ZERO_REG && (rt == '0))) begin
            if (BYPASS && wr_ok && (rd == rt)) begin
                read_data2 = write_data;
            end else begin
                read_data2 = mem_q[rt];
                busy2      = busy_q[rt];
            end
        end
    end

    assign init_done = run;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//   Scoreboard bench for regfile_sb. Three instances share the stimulus:
//     dut 0: ZERO_REG=1, BYPASS=1 (default)
//     dut 1: ZERO_REG=1, BYPASS=0
//     dut 2: ZERO_REG=0, BYPASS=1
//   Stimulus queues expected values; a negedge monitor drains the queue and
//   compares against the live combinational outputs.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [4:0]  rs, rt, rd, reserve_addr;
    logic        reg_write, reserve;
    logic [31:0] write_data;

    logic [31:0] rd1 [3];
    logic [31:0] rd2 [3];
    logic        b1  [3];
    logic        b2  [3];
    logic        idn [3];

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
        .reg_write(reg_write), .write_data(write_data),
        .reserve(reserve), .reserve_addr(reserve_addr),
        .read_data1(rd1[0]), .read_data2(rd2[0]),
        .busy1(b1[0]), .busy2(b2[0]), .init_done(idn[0])
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
        .reg_write(reg_write), .write_data(write_data),
        .reserve(reserve), .reserve_addr(reserve_addr),
        .read_data1(rd1[1]), .read_data2(rd2[1]),
        .busy1(b1[1]), .busy2(b2[1]), .init_done(idn[1])
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_c (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
        .reg_write(reg_write), .write_data(write_data),
        .reserve(reserve), .reserve_addr(reserve_addr),
        .read_data1(rd1[2]), .read_data2(rd2[2]),
        .busy1(b1[2]), .busy2(b2[2]), .init_done(idn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int F_RD1 = 0;
    localparam int F_RD2 = 1;
    localparam int F_B1  = 2;
    localparam int F_B2  = 3;
    localparam int F_ID  = 4;

    typedef struct {
        string       name;
        int          dut;
        int          fld;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] actual(input int d, input int f);
        case (f)
            F_RD1:   return rd1[d];
            F_RD2:   return rd2[d];
            F_B1:    return {31'b0, b1[d]};
            F_B2:    return {31'b0, b2[d]};
            default: return {31'b0, idn[d]};
        endcase
    endfunction

    task automatic exp_chk(input string n, input int d, input int f, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.dut  = d;
        c.fld  = f;
        c.exp  = e;
        q.push_back(c);
    endtask

    task automatic drive(input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic [4:0] a_rd, input logic we,
                         input logic [31:0] wd, input logic res,
                         input logic [4:0] ra);
        rs           = a_rs;
        rt           = a_rt;
        rd           = a_rd;
        reg_write    = we;
        write_data   = wd;
        reserve      = res;
        reserve_addr = ra;
    endtask

    task automatic idle(input logic [4:0] a_rs, input logic [4:0] a_rt);
        drive(a_rs, a_rt, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every queued expectation against the outputs.
    always @(negedge clk) begin : mon
        chk_t        c;
        logic [31:0] a;
        while (q.size() != 0) begin
            c = q.pop_front();
            a = actual(c.dut, c.fld);
            checks++;
            if (a !== c.exp) begin
                errors++;
                $display("FAIL %s: dut%0d got %h expected %h", c.name, c.dut, a, c.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle(5'd5, 5'd6);
        exp_chk("rst_rd1",  0, F_RD1, 32'h0);
        exp_chk("rst_rd2",  0, F_RD2, 32'h0);
        exp_chk("rst_busy1", 0, F_B1, 32'h0);
        exp_chk("rst_busy2", 0, F_B2, 32'h0);
        exp_chk("rst_init_done", 0, F_ID, 32'h0);
        tick;
        tick;
        reset = 1'b0;

        // Clear sequence: edges 1..32 after release; write/reserve r3 before
        // edge 10 must be ignored (r3 was already cleared at edge 4).
        for (int k = 1; k <= 32; k++) begin
            tick;
            if (k == 9) begin
                drive(5'd3, 5'd3, 5'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd3);
                exp_chk("init_rd1_zero", 0, F_RD1, 32'h0);
                exp_chk("init_busy1_zero", 0, F_B1, 32'h0);
            end else if (k == 10) begin
                idle(5'd3, 5'd3);
            end
            if (k == 31) exp_chk("init_done_e31", 0, F_ID, 32'h0);
            if (k == 32) begin
                exp_chk("init_done_e32", 0, F_ID, 32'h1);
                exp_chk("init_done_e32", 1, F_ID, 32'h1);
                exp_chk("init_done_e32", 2, F_ID, 32'h1);
            end
        end

        // Every entry reads 0; r3 untouched by the INIT-time write/reserve.
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(31 - i));
            exp_chk("clear_rd1", 0, F_RD1, 32'h0);
            exp_chk("clear_rd2", 0, F_RD2, 32'h0);
            exp_chk("clear_busy1", 0, F_B1, 32'h0);
            exp_chk("clear_rd1_nz", 2, F_RD1, 32'h0);
            tick;
        end

        // Bypass vs no-bypass on r5.
        drive(5'd5, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0);
        exp_chk("byp_rd1", 0, F_RD1, 32'hDEAD_BEEF);
        exp_chk("byp_rd2", 0, F_RD2, 32'hDEAD_BEEF);
        exp_chk("nobyp_rd1_pre", 1, F_RD1, 32'h0);
        exp_chk("nobyp_rd2_pre", 1, F_RD2, 32'h0);
        tick;
        idle(5'd5, 5'd5);
        exp_chk("byp_rd1_post", 0, F_RD1, 32'hDEAD_BEEF);
        exp_chk("nobyp_rd1_post", 1, F_RD1, 32'hDEAD_BEEF);
        exp_chk("nobyp_rd2_post", 1, F_RD2, 32'hDEAD_BEEF);
        tick;

        // Write + reserve r0: hardwired in dut 0/1, ordinary in dut 2.
        drive(5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_1234, 1'b1, 5'd0);
        exp_chk("zr_rd1_wcyc", 0, F_RD1, 32'h0);
        exp_chk("nz_rd1_wcyc_byp", 2, F_RD1, 32'h0000_1234);
        exp_chk("nz_busy1_wcyc_byp", 2, F_B1, 32'h0);
        tick;
        idle(5'd0, 5'd0);
        exp_chk("zr_rd1", 0, F_RD1, 32'h0);
        exp_chk("zr_busy1", 0, F_B1, 32'h0);
        exp_chk("zr_rd1_nobyp", 1, F_RD1, 32'h0);
        exp_chk("nz_rd1", 2, F_RD1, 32'h0000_1234);
        exp_chk("nz_busy1", 2, F_B1, 32'h1);
        exp_chk("nz_busy2", 2, F_B2, 32'h1);
        tick;

        // Reserve r7, then write it.
        drive(5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 1'b1, 5'd7);
        exp_chk("res7_busy1_pre", 0, F_B1, 32'h0);
        tick;
        idle(5'd7, 5'd7);
        exp_chk("res7_busy1", 0, F_B1, 32'h1);
        exp_chk("res7_busy2", 0, F_B2, 32'h1);
        tick;
        drive(5'd7, 5'd7, 5'd7, 1'b1, 32'h55, 1'b0, 5'd0);
        exp_chk("wr7_busy1_byp", 0, F_B1, 32'h0);
        exp_chk("wr7_rd1_byp", 0, F_RD1, 32'h55);
        exp_chk("wr7_busy1_nobyp", 1, F_B1, 32'h1);
        exp_chk("wr7_rd1_nobyp", 1, F_RD1, 32'h0);
        tick;
        idle(5'd7, 5'd7);
        exp_chk("wr7_busy1_post", 0, F_B1, 32'h0);
        exp_chk("wr7_rd1_post", 0, F_RD1, 32'h55);
        exp_chk("wr7_busy1_post_nb", 1, F_B1, 32'h0);
        exp_chk("wr7_rd1_post_nb", 1, F_RD1, 32'h55);
        tick;
        drive(5'd7, 5'd7, 5'd7, 1'b1, 32'h55, 1'b1, 5'd7);
        tick;
        idle(5'd7, 5'd7);
        exp_chk("wr_res7_busy1", 0, F_B1, 32'h1);
        exp_chk("wr_res7_rd1", 0, F_RD1, 32'h55);
        exp_chk("wr_res7_busy2_nb", 1, F_B2, 32'h1);
        tick;

        // r3 busy and holding data, then reset in RUN.
        drive(5'd3, 5'd3, 5'd3, 1'b1, 32'h0000_ABCD, 1'b1, 5'd3);
        tick;
        idle(5'd3, 5'd3);
        exp_chk("r3_busy1", 0, F_B1, 32'h1);
        exp_chk("r3_rd1", 0, F_RD1, 32'h0000_ABCD);
        exp_chk("r3_init_done", 0, F_ID, 32'h1);
        tick;
        reset = 1'b1;
        exp_chk("rrst_busy1", 0, F_B1, 32'h0);
        exp_chk("rrst_init_done", 0, F_ID, 32'h0);
        exp_chk("rrst_rd1", 0, F_RD1, 32'h0);
        tick;
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick;
            if (k == 31) exp_chk("rinit_done_e31", 0, F_ID, 32'h0);
            if (k == 32) exp_chk("rinit_done_e32", 0, F_ID, 32'h1);
        end
        exp_chk("rinit_r3_rd1", 0, F_RD1, 32'h0);
        exp_chk("rinit_r3_busy1", 0, F_B1, 32'h0);
        exp_chk("rinit_r3_rd1_nb", 1, F_RD1, 32'h0);
        tick;
        tick;

        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d checks pending, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
